// File: rtl/serial_atx_if.sv
// Byte-write and line-status bundle of the serial_atx transmitter.
// The master side (CPU/IO port) writes bytes and supplies the baud tick;
// the slave side (transmitter) drives the line and the status flags.
interface serial_atx_if;
   logic       baudtick;
   logic [7:0] txd_data;
   logic       txd_start;
   logic       txd_full;
   logic       txd_overflow;
   logic       txd_busy;
   logic       txd_idle;
   logic       txd;

   modport master (
      output baudtick,
      output txd_data,
      output txd_start,
      input  txd_full,
      input  txd_overflow,
      input  txd_busy,
      input  txd_idle,
      input  txd
   );

   modport slave (
      input  baudtick,
      input  txd_data,
      input  txd_start,
      output txd_full,
      output txd_overflow,
      output txd_busy,
      output txd_idle,
      output txd
   );
endinterface

// File: rtl/serial_atx.sv
// RS-232 asynchronous transmitter: 8 data bits, no parity, 1 or 2 stop
// bits, LSB first. A small write FIFO absorbs CPU bursts so consecutive
// frames leave back-to-back; bit timing comes from an external 1x baud tick.
module serial_atx #(
   parameter int FIFO_AW   = 2,   // log2 of FIFO depth
   parameter int STOP_BITS = 1    // 1 or 2
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_atx_if.slave bus
);

   localparam int                 DEPTH     = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
   // Stop counter value that marks the final stop bit of a frame.
   localparam logic               STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Line state machine registers
   state_t       r_state;
   logic [7:0]   r_sh;
   logic [2:0]   r_bitcnt;
   logic         r_stopcnt;
   logic         r_txd;

   // Write FIFO registers
   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_full;
   logic               r_overflow;

   // Shared decisions between FIFO and state machine
   logic               w_empty;
   logic               w_last_stop;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [7:0]         w_head;
   logic [FIFO_AW:0]   w_count_nxt;

   assign w_empty     = (r_count == '0);
   assign w_last_stop = (r_stopcnt == STOP_LAST);
   // A byte leaves the FIFO only on a tick when the line is free: either idle,
   // or at the end of the last stop bit (back-to-back frames).
   assign w_pop       = bus.baudtick && !w_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last_stop));
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_push      = bus.txd_start && ((r_count != DEPTH_C) || w_pop);
   assign w_drop      = bus.txd_start && !w_push;
   assign w_head      = r_mem[r_rd_ptr];

   // Next occupancy; push and pop together leave the count unchanged.
   always_comb begin
      // NOTE: default first so every path assigns it and no latch is inferred.
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO pointers, occupancy and registered full/overflow flags.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == DEPTH_C);
         r_overflow <= w_drop;
      end
   end

   // FIFO storage; contents are only meaningful below the count.
   // NOTE: the storage array has no reset: the pointers/count define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.txd_data;
   end

   // Frame sequencer; every transition and line change happens on a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_txd     <= 1'b1;
      end else if (bus.baudtick) begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_sh    <= w_head;
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end else begin
                  r_txd   <= 1'b1;
               end
            end
            S_START: begin
               r_txd    <= r_sh[0];
               r_sh     <= r_sh >> 1;
               r_bitcnt <= '0;
               r_state  <= S_DATA;
            end
            S_DATA: begin
               if (r_bitcnt == 3'd7) begin
                  r_txd     <= 1'b1;
                  r_stopcnt <= 1'b0;
                  r_state   <= S_STOP;
               end else begin
                  r_txd    <= r_sh[0];
                  r_sh     <= r_sh >> 1;
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
            end
            S_STOP: begin
               if (!w_last_stop) begin
                  r_stopcnt <= 1'b1;
                  r_txd     <= 1'b1;
               end else if (w_pop) begin
                  r_sh    <= w_head;
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end else begin
                  r_txd   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.txd          = r_txd;
   assign bus.txd_busy     = (r_state != S_IDLE);
   assign bus.txd_idle     = (r_state == S_IDLE) && w_empty;
   assign bus.txd_full     = r_full;
   assign bus.txd_overflow = r_overflow;

endmodule

// File: tb/tb_serial_atx.sv
// Self-checking bench for serial_atx: a tick-level reference model predicts
// line level and status every clock, and a frame decoder on txd checks each
// received byte against a scoreboard of accepted writes.
module tb_serial_atx;

   localparam int DEPTH = 4;
   localparam int FRAME = 10;   // bit periods per frame for the main DUT

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   serial_atx_if if1 ();
   serial_atx_if if2 ();

   serial_atx #(.FIFO_AW(2), .STOP_BITS(1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   serial_atx #(.FIFO_AW(2), .STOP_BITS(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   always #5 clk = ~clk;

   assign if2.baudtick = if1.baudtick;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Baud tick generator: high for one clk every tick_period clks
   int tick_period = 16;
   int tick_cnt    = 0;
   initial begin
      if1.baudtick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_cnt + 1 >= tick_period) begin
            tick_cnt     = 0;
            if1.baudtick = 1'b1;
         end else begin
            tick_cnt++;
            if1.baudtick = 1'b0;
         end
      end
   end

   // Reference model: FIFO as a queue, line as "bit periods left in frame"
   logic [7:0]  m_fifo [$];
   logic [7:0]  exp_q  [$];
   int          m_left = 0;
   logic [10:0] m_frame = '1;
   logic        m_txd  = 1'b1;
   logic        m_ovf  = 1'b0;

   task automatic model_step();
      logic [7:0] b;
      bit         pop;
      pop = 0;
      if (if1.baudtick) begin
         if (m_left > 0) m_left--;
         if (m_left == 0 && m_fifo.size() > 0) pop = 1;
      end
      if (pop) begin
         b       = m_fifo.pop_front();
         m_frame = {2'b11, b, 1'b0};
         m_left  = FRAME;
      end
      m_ovf = 1'b0;
      if (if1.txd_start) begin
         if (m_fifo.size() < DEPTH) begin
            m_fifo.push_back(if1.txd_data);
            exp_q.push_back(if1.txd_data);
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_txd = (m_left > 0) ? m_frame[FRAME - m_left] : 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_left = 0;
            m_txd  = 1'b1;
            m_ovf  = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   // Cycle checker: line level and status against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("txd",      if1.txd,          m_txd);
            check("busy",     if1.txd_busy,     m_left > 0);
            check("idle",     if1.txd_idle,     (m_left == 0) && (m_fifo.size() == 0));
            check("full",     if1.txd_full,     m_fifo.size() == DEPTH);
            check("overflow", if1.txd_overflow, m_ovf);
         end
      end
   end

   // Monitor: decode frames from txd at each bit boundary, pop the scoreboard
   initial begin
      logic [7:0] sh;
      int         nb;
      bit         in_f;
      logic       t;
      sh   = '0;
      nb   = 0;
      in_f = 0;
      forever begin
         @(posedge clk);
         t = if1.baudtick;
         @(negedge clk);
         if (!rst_n) begin
            in_f = 0;
            continue;
         end
         if (!t) continue;
         if (!in_f) begin
            if (if1.txd == 1'b0) begin
               in_f = 1;
               nb   = 0;
            end
         end else if (nb < 8) begin
            sh = {if1.txd, sh[7:1]};
            nb++;
         end else begin
            check("stop_bit", if1.txd, 1'b1);
            check("frame_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("frame_byte", sh, exp_q.pop_front());
            in_f = 0;
         end
      end
   end

   // Stimulus helpers; all are entered and left 2 time units after a posedge
   task automatic wr(input logic [7:0] b);
      if1.txd_data  = b;
      if1.txd_start = 1'b1;
      @(posedge clk);
      #2;
      if1.txd_start = 1'b0;
   endtask

   task automatic wr2(input logic [7:0] b);
      if2.txd_data  = b;
      if2.txd_start = 1'b1;
      @(posedge clk);
      #2;
      if2.txd_start = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Wait until the coming edge carries a tick
   task automatic wait_tick();
      int c;
      c = 0;
      while (!if1.baudtick && c < 200) begin
         step(1);
         c++;
      end
      check("tick_in_time", if1.baudtick, 1'b1);
   endtask

   task automatic wait_drained(input int budget);
      int c;
      c = 0;
      while (!(if1.txd_idle && m_left == 0 && m_fifo.size() == 0) && c < budget) begin
         step(1);
         c++;
      end
      check("drained_in_time", if1.txd_idle, 1'b1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       exp_bits [$];
      logic       got_bits [$];
      logic       t;
      int         c;

      if1.txd_start = 1'b0;
      if1.txd_data  = '0;
      if2.txd_start = 1'b0;
      if2.txd_data  = '0;

      // Reset values
      step(3);
      check("rst_txd",      if1.txd,          1'b1);
      check("rst_busy",     if1.txd_busy,     1'b0);
      check("rst_idle",     if1.txd_idle,     1'b1);
      check("rst_full",     if1.txd_full,     1'b0);
      check("rst_overflow", if1.txd_overflow, 1'b0);
      rst_n = 1'b1;
      step(5);

      // Single byte 0x55
      wr(8'h55);
      wait_drained(400);

      // Back-to-back burst starting on a tick cycle: first write not popped by it
      wait_tick();
      wr(8'hA3);
      wr(8'h0F);
      wr(8'hFF);
      wr(8'h00);
      check("full_after_4", if1.txd_full, 1'b1);
      wait_drained(1000);

      // Overflow: fill, then a fifth write with no pop is dropped
      wait_tick();
      wr(8'h01);
      wr(8'h02);
      wr(8'h03);
      wr(8'h04);
      wr(8'h12);
      check("ovf_pulse", if1.txd_overflow, 1'b1);
      step(1);
      check("ovf_one_clk", if1.txd_overflow, 1'b0);
      wait_drained(1000);

      // Collision: full FIFO, write coincides with the STOP->START pop
      wait_tick();
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h44);
      c = 0;
      while (if1.txd_full && c < 200) begin step(1); c++; end
      wr(8'h55);
      c = 0;
      while (!(if1.baudtick && m_left == 1 && m_fifo.size() == DEPTH) && c < 400) begin
         step(1);
         c++;
      end
      check("collision_reached", m_fifo.size() == DEPTH && m_left == 1, 1'b1);
      wr(8'hC6);
      check("collision_ovf",  if1.txd_overflow, 1'b0);
      check("collision_full", if1.txd_full,     1'b1);
      wait_drained(1500);

      // Asynchronous reset mid-frame after three data bits
      wr(8'hB4);
      wr(8'h5A);
      c = 0;
      while (m_left != 6 && c < 400) begin step(1); c++; end
      step(5);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_txd",  if1.txd,      1'b1);
      check("arst_busy", if1.txd_busy, 1'b0);
      check("arst_idle", if1.txd_idle, 1'b1);
      check("arst_full", if1.txd_full, 1'b0);
      step(3);
      rst_n = 1'b1;
      step(60);
      check("no_resume_idle", if1.txd_idle, 1'b1);
      check("no_resume_txd",  if1.txd,      1'b1);

      // Randomised traffic with varying tick spacing (including every clk)
      for (int i = 0; i < 300; i++) begin
         if (i % 40 == 0) tick_period = $urandom_range(20, 1);
         b = 8'($urandom());
         wr(b);
         step($urandom_range(30, 0));
      end
      tick_period = 16;
      wait_drained(5000);
      step(2);
      check("scoreboard_empty", exp_q.size(), 0);

      // Two stop bits: 0x80 then 0x01, sampled at every bit boundary
      for (int k = 0; k < 2; k++) begin
         b = (k == 0) ? 8'h80 : 8'h01;
         exp_bits.push_back(1'b0);
         for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
         exp_bits.push_back(1'b1);
         exp_bits.push_back(1'b1);
      end
      exp_bits.push_back(1'b1);   // line idle after the second frame
      wait_tick();
      wr2(8'h80);
      wr2(8'h01);
      c = 0;
      while (got_bits.size() < exp_bits.size() && c < 2000) begin
         @(posedge clk);
         t = if1.baudtick;
         @(negedge clk);
         if (t) got_bits.push_back(if2.txd);
         c++;
      end
      check("sb2_bit_count", got_bits.size(), exp_bits.size());
      for (int j = 0; j < exp_bits.size() && j < got_bits.size(); j++)
         check($sformatf("sb2_bit%0d", j), got_bits[j], exp_bits[j]);
      step(1);
      check("sb2_idle", if2.txd_idle, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
